// File: rtl/neopixel_rx_if.sv
// Register bus for neopixel_rx: access strobes, block select, address,
// write data and combinational read data.
// Ports: master = bus side (drives strobes/address/data), slave = neopixel_rx.
interface neopixel_rx_if;
  logic        bus_write_en;
  logic        bus_read_en;
  logic        np_rx_en;
  logic [7:0]  bus_addr;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;

  modport master (
    output bus_write_en, bus_read_en, np_rx_en, bus_addr, bus_write_data,
    input  bus_read_data
  );

  modport slave (
    input  bus_write_en, bus_read_en, np_rx_en, bus_addr, bus_write_data,
    output bus_read_data
  );
endinterface

// File: rtl/neopixel_rx.sv
// Purpose: WS2812 single-wire NRZ receiver, decodes pulse widths into 24-bit words
//          held in a small FIFO, with framing/overflow status on a register bus.
// Latency: np_in edge seen by the FSM after 3 cycles; word readable the cycle after
//          its 24th falling edge is decoded. Backpressure: none on the wire side; a
//          word arriving at a full FIFO is dropped and flagged (ovf).
// Ports: pclk, nreset (async active-low), bus (neopixel_rx_if.slave: strobes, select,
//        addr, wdata, combinational rdata), np_in (async serial), np_irq (NP_RX_IRQ_EN).
// Optional feature macro: NP_RX_IRQ_EN adds the registered np_irq output.
module neopixel_rx #(
  parameter int BIT_THRESH = 60,
  parameter int MIN_HIGH   = 10,
  parameter int MAX_HIGH   = 100,
  parameter int RESET_LOW  = 5000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                pclk,
  input  logic                nreset,
  neopixel_rx_if.slave        bus,
  input  logic                np_in
`ifdef NP_RX_IRQ_EN
  ,
  output logic                np_irq
`endif
);
  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  logic          sync1_q, s_in_q, prev_q;
  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [13:0]   lcnt_q, lcnt_d;
  logic [4:0]    bitcnt_q, bitcnt_d;
  logic [23:0]   shreg_q, shreg_d;
  logic [23:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;
  logic          ovf_q, ovf_d, frm_q, frm_d, fd_q, fd_d;

  logic rise, fall, bit_val;
  logic push_req, set_frm, set_fd;
  logic [23:0] push_word;
  logic wr_acc, rd_acc, data_wr, stat_wr, data_rd, flush;
  logic empty, full, pop, do_push, ovf_set;
  logic [2:0] clr;
  logic unused_wdata;

  assign rise    = s_in_q & ~prev_q;
  assign fall    = ~s_in_q & prev_q;
  assign bit_val = (hcnt_q >= HW'(BIT_THRESH));

  assign wr_acc  = bus.bus_write_en & bus.np_rx_en;
  assign rd_acc  = bus.bus_read_en & bus.np_rx_en;
  assign data_wr = wr_acc && (bus.bus_addr == 8'h00);
  assign stat_wr = wr_acc && (bus.bus_addr == 8'h04);
  assign data_rd = rd_acc && (bus.bus_addr == 8'h00);
  assign flush   = data_wr & bus.bus_write_data[0];
  assign clr     = stat_wr ? bus.bus_write_data[8:6] : 3'b000;
  assign unused_wdata = ^{bus.bus_write_data[31:9], bus.bus_write_data[5:1]};

  // Pulse-width decoder
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    lcnt_d    = lcnt_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    push_req  = 1'b0;
    set_frm   = 1'b0;
    set_fd    = 1'b0;
    push_word = {shreg_q[22:0], bit_val};
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          hcnt_d  = HW'(1);
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_d = ST_LOW;
          lcnt_d  = 14'd1;
          if (hcnt_q < HW'(MIN_HIGH)) begin
            // glitch: ignored entirely
          end else if (hcnt_q > HW'(MAX_HIGH)) begin
            set_frm  = 1'b1;
            bitcnt_d = 5'd0;
          end else begin
            shreg_d = push_word;
            if (bitcnt_q == 5'd23) begin
              push_req = 1'b1;
              bitcnt_d = 5'd0;
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end
        end else if (hcnt_q != HW'(MAX_HIGH + 1)) begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d = ST_HIGH;
          hcnt_d  = HW'(1);
        end else if (lcnt_q >= 14'(RESET_LOW)) begin
          // latch gap: frame ends, any partial word is a framing error
          set_fd   = 1'b1;
          set_frm  = (bitcnt_q != 5'd0);
          bitcnt_d = 5'd0;
          state_d  = ST_IDLE;
        end else begin
          lcnt_d = lcnt_q + 14'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d  = ST_IDLE;
      bitcnt_d = 5'd0;
      push_req = 1'b0;
      set_frm  = 1'b0;
      set_fd   = 1'b0;
    end
  end

  // Word FIFO; a pop frees the slot for a simultaneous push when full
  assign empty   = (count_q == 4'd0);
  assign full    = (count_q == 4'(FIFO_DEPTH));
  assign pop     = data_rd & ~empty;
  assign do_push = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Set beats a simultaneous write-1-to-clear
  assign ovf_d = (ovf_q & ~clr[0]) | ovf_set;
  assign frm_d = (frm_q & ~clr[1]) | set_frm;
  assign fd_d  = (fd_q  & ~clr[2]) | set_fd;

  always_comb begin
    bus.bus_read_data = 32'd0;
    if (rd_acc) begin
      if (bus.bus_addr == 8'h00) begin
        if (!empty) bus.bus_read_data = {8'd0, mem_q[rd_ptr_q]};
      end else if (bus.bus_addr == 8'h04) begin
        bus.bus_read_data = {18'd0, bitcnt_q, fd_q, frm_q, ovf_q, full, empty, count_q};
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      sync1_q  <= 1'b0;
      s_in_q   <= 1'b0;
      prev_q   <= 1'b0;
      state_q  <= ST_IDLE;
      hcnt_q   <= '0;
      lcnt_q   <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      frm_q    <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      sync1_q  <= np_in;
      s_in_q   <= sync1_q;
      prev_q   <= s_in_q;
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      lcnt_q   <= lcnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      frm_q    <= frm_d;
      fd_q     <= fd_d;
    end
  end

`ifdef NP_RX_IRQ_EN
  logic irq_q;
  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) irq_q <= 1'b0;
    else         irq_q <= ~empty | ovf_q | frm_q | fd_q;
  end
  assign np_irq = irq_q;
`endif
endmodule
